sram_axi_bridge: RTL
====================

# sram_axi_bridge

Parametrised bridge converting the CPU's two SRAM-like request ports (instruction fetch, data access) into a single AXI3 master interface. It replaces the direct inst/data SRAM ports at the CPU top boundary, allowing IF and EX/MEM to issue split address/data transactions against an AXI fabric with multiple reads in flight per port. Responses are returned strictly in order per port.

## Interface
Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 32, data width; WSTRB width = DATA_W/8
- RD_DEPTH, 2, max outstanding reads per port (1..7)

Ports (SRAM-like sides use `inst_` / `data_` prefix, same set each):
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high (top drives it from ~resetn)
- {inst,data}_sram_req  in  1  request valid
- {inst,data}_sram_wr  in  1  1 = write; inst_sram_wr ignored (inst port read-only)
- {inst,data}_sram_size  in  2  0/1/2 = byte/half/word
- {inst,data}_sram_addr  in  ADDR_W  byte address
- {inst,data}_sram_wstrb  in  DATA_W/8  write byte enables
- {inst,data}_sram_wdata  in  DATA_W  write data
- {inst,data}_sram_addr_ok  out  1  request accepted this cycle
- {inst,data}_sram_data_ok  out  1  response for oldest accepted request
- {inst,data}_sram_rdata  out  DATA_W  read data, valid with data_ok
- AXI3 master: ar{id[3:0],addr,len[7:0],size[2:0],burst,lock,cache,prot,valid,ready}, r{id,data,resp,last,valid,ready}, aw{…same…}, w{id,data,strb,last,valid,ready}, b{id,resp,valid,ready}

## Operation
- Fixed AXI fields: len=0, burst=2'b01, lock/cache/prot=0, wlast=1, awid=wid=1, size={1'b0,sram_size}.
- ARID: inst = 0, data = 1. R routed by rid[0]; rready constant 1.
- Read FSM RD_IDLE/RD_AR: in RD_IDLE, a port's read is accepted (addr_ok=1, combinational) if its outstanding count < RD_DEPTH and it wins arbitration; request latched, go RD_AR with arvalid=1; return to RD_IDLE on arready.
- Arbitration: see Configuration.
- Per-port outstanding counter: +1 on addr_ok (read), −1 on R handshake with matching id; both same cycle → unchanged.
- Write FSM WR_IDLE/WR_SEND/WR_RESP: data write accepted only in WR_IDLE with data read count = 0 and read FSM not taking the data port this cycle. WR_SEND drives awvalid and wvalid together; each drops independently on its own handshake; both done → WR_RESP. WR_RESP: bready = !(rvalid && rid==1); on B handshake data_sram_data_ok=1, → WR_IDLE.
- Data read accepted only when write FSM is WR_IDLE (keeps data_ok in order across R and B).
- data_ok (read) = rvalid && rid matches port; rdata = AXI rdata passthrough.
- rresp/bresp ignored.

## Timing
- Reset: all valids 0, bready 0, counters 0, FSMs idle, addr_ok/data_ok 0, rdata passthrough.
- Read latency: req+addr_ok cycle 0, arvalid cycle 1; arready=1 at cycle 1 and rvalid at cycle 2 → data_ok cycle 2.
- Write: addr_ok cycle 0, aw/wvalid cycle 1, earliest data_ok same cycle as bvalid (cycle 2).
- Count == RD_DEPTH: addr_ok held 0 until an R for that port retires (request accepted same cycle as retire).
- Reset mid-transaction: state cleared in one cycle; in-flight AXI responses after reset are not required to be handled.

## Configuration
- BRIDGE_DATA_PRIO_EN defined: data port always wins AR arbitration over inst.
- Undefined: round-robin; one-bit last-grant register flips on each contested grant (reset to inst-last, so data wins first contest).

## Structure
- Package `bridge_pkg`: ARID constants, RD_*/WR_* state encodings, fixed AXI field constants.
- Sub-module `bridge_rd_tracker` (per port, instantiated twice): saturating outstanding counter with full flag, parameter RD_DEPTH.

## Test plan
- Single inst read 0x1c000000, arready=1, rvalid next cycle with 0x02c0000c → inst data_ok cycle 2, rdata 0x02c0000c.
- RD_DEPTH=2, three back-to-back inst reads, R withheld → third addr_ok 0 until first R; data_ok order matches addr order.
- Data write 0x8000_0010, wstrb 0xF, awready 1 cycle before wready → aw/w drop separately, B → data_ok once.
- Data read while write in WR_RESP → addr_ok 0 until B handshake; rvalid(id1) with bvalid same cycle → bready 0, read data_ok first.
- Both ports request continuously: with BRIDGE_DATA_PRIO_EN all grants to data; without, grants alternate data, inst, data.
- Reset asserted during RD_AR → next cycle arvalid 0, counters 0, addr_ok accepted for new request.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared constants and state encodings for the SRAM-like to AXI3 bridge.
package bridge_pkg;

    localparam logic [3:0] ARID_INST = 4'd0;
    localparam logic [3:0] ARID_DATA = 4'd1;
    localparam logic [3:0] AWID_DATA = 4'd1;

    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'd0;
    localparam logic [2:0] AXI_PROT  = 3'd0;

    typedef enum logic {
        RD_IDLE,
        RD_AR
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SEND,
        WR_RESP
    } wr_state_t;

    function automatic logic [2:0] axi_size(input logic [1:0] s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/bridge_rd_tracker.sv
// Per-port outstanding read counter, saturating at RD_DEPTH.
module bridge_rd_tracker #(
    parameter int RD_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [2:0] cnt;
    logic       dec_eff;

    // A stray response with nothing outstanding must not wrap the count.
    assign dec_eff = dec && !empty;
    assign full    = (cnt == 3'(RD_DEPTH));
    assign empty   = (cnt == 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (inc && !dec_eff && !full) begin
            cnt <= cnt + 3'd1;
        end else if (dec_eff && !inc) begin
            cnt <= cnt - 3'd1;
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges inst/data SRAM-like ports onto one AXI3 master, in-order per port.
// Build option: BRIDGE_DATA_PRIO_EN gives the data port fixed AR priority.
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_sram_req,
    input  logic                inst_sram_wr,
    input  logic [1:0]          inst_sram_size,
    input  logic [ADDR_W-1:0]   inst_sram_addr,
    input  logic [DATA_W/8-1:0] inst_sram_wstrb,
    input  logic [DATA_W-1:0]   inst_sram_wdata,
    output logic                inst_sram_addr_ok,
    output logic                inst_sram_data_ok,
    output logic [DATA_W-1:0]   inst_sram_rdata,

    input  logic                data_sram_req,
    input  logic                data_sram_wr,
    input  logic [1:0]          data_sram_size,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W/8-1:0] data_sram_wstrb,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic                data_sram_addr_ok,
    output logic                data_sram_data_ok,
    output logic [DATA_W-1:0]   data_sram_rdata,

    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,

    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,

    output logic [3:0]          wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    rd_state_t rd_state;
    wr_state_t wr_state;

    logic inst_full, inst_empty;
    logic data_full, data_empty;
    logic inst_ret, data_ret;
    logic inst_rd_req, data_rd_req;
    logic grant_inst, grant_data;
    logic wr_accept, b_hs;
    logic unused_ok;

    assign inst_ret = rvalid && (rid[0] == ARID_INST[0]);
    assign data_ret = rvalid && (rid[0] == ARID_DATA[0]);

    // A retiring response frees its slot in the same cycle.
    assign inst_rd_req = (rd_state == RD_IDLE) && inst_sram_req
                      && (!inst_full || inst_ret);
    assign data_rd_req = (rd_state == RD_IDLE) && data_sram_req
                      && !data_sram_wr && (wr_state == WR_IDLE)
                      && (!data_full || data_ret);

`ifdef BRIDGE_DATA_PRIO_EN
    assign grant_data = data_rd_req;
`else
    logic last_data;

    assign grant_data = data_rd_req && (!inst_rd_req || !last_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_data <= 1'b0;
        end else if (inst_rd_req && data_rd_req) begin
            last_data <= grant_data;
        end
    end
`endif

    assign grant_inst = inst_rd_req && !grant_data;

    assign wr_accept = (wr_state == WR_IDLE) && data_sram_req
                    && data_sram_wr && data_empty && !grant_data;

    // B waits while a data-port R beat is on the bus.
    assign bready = (wr_state == WR_RESP) && !data_ret;
    assign b_hs   = bvalid && bready;

    assign inst_sram_addr_ok = grant_inst;
    assign data_sram_addr_ok = grant_data || wr_accept;
    assign inst_sram_data_ok = inst_ret;
    assign data_sram_data_ok = data_ret || b_hs;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arlen   = AXI_LEN;
    assign arburst = AXI_BURST;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign rready  = 1'b1;

    assign awid    = AWID_DATA;
    assign awlen   = AXI_LEN;
    assign awburst = AXI_BURST;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;
    assign wid     = AWID_DATA;
    assign wlast   = 1'b1;

    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                         rresp, rlast, rid[3:1], bid, bresp};

    bridge_rd_tracker #(.RD_DEPTH(RD_DEPTH)) u_inst_trk (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_inst),
        .dec   (inst_ret),
        .full  (inst_full),
        .empty (inst_empty)
    );

    bridge_rd_tracker #(.RD_DEPTH(RD_DEPTH)) u_data_trk (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_data),
        .dec   (data_ret),
        .full  (data_full),
        .empty (data_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            arvalid  <= 1'b0;
            arid     <= ARID_INST;
            araddr   <= '0;
            arsize   <= 3'd0;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (grant_inst || grant_data) begin
                        rd_state <= RD_AR;
                        arvalid  <= 1'b1;
                        arid     <= grant_data ? ARID_DATA : ARID_INST;
                        araddr   <= grant_data ? data_sram_addr
                                               : inst_sram_addr;
                        arsize   <= grant_data ? axi_size(data_sram_size)
                                               : axi_size(inst_sram_size);
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        rd_state <= RD_IDLE;
                        arvalid  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            awaddr   <= '0;
            awsize   <= 3'd0;
            wdata    <= '0;
            wstrb    <= '0;
        end else begin
            unique case (wr_state)
                WR_IDLE: begin
                    if (wr_accept) begin
                        wr_state <= WR_SEND;
                        awvalid  <= 1'b1;
                        wvalid   <= 1'b1;
                        awaddr   <= data_sram_addr;
                        awsize   <= axi_size(data_sram_size);
                        wdata    <= data_sram_wdata;
                        wstrb    <= data_sram_wstrb;
                    end
                end
                WR_SEND: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) wr_state <= WR_IDLE;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

endmodule
